chart_recorder: RTL
===================

Name: chart_recorder

Overview:
Record-mode writer for the rhythm game chart memory, and the counterpart of note_gen, which plays charts back from that memory. It captures debounced play-button presses from button_ctrl and timestamps each one in 1 ms ticks from clk_div. It coalesces presses that fall in the same millisecond into one entry. It writes the entries sequentially through a single-cycle RAM write port and closes the chart with a terminator entry.

Parameters:
- DEPTH, 256: chart RAM entries, including the terminator slot.
- ADDR_W, 8: address width; clog2(DEPTH).
- TIME_W, 32: timestamp width in ms.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- i_tick  in  1  1 ms strobe, one clk wide
- i_play  in  2  debounced play buttons, level; [1] track2 (down), [0] track1 (up)
- i_rec_start  in  1  pulse; begin a recording
- i_rec_stop  in  1  pulse; end a recording
- o_wr_en  out  1  RAM write strobe, one cycle
- o_wr_addr  out  ADDR_W  RAM write address
- o_wr_data  out  TIME_W+2  entry: [TIME_W+1:TIME_W] track mask, [TIME_W-1:0] ms since start
- o_recording  out  1  high in REC
- o_done  out  1  high in DONE
- o_count  out  ADDR_W+1  note entries written (terminator excluded)
- o_overflow  out  1  sticky: a press was dropped because the chart was full

Behaviour:
- Reset: all outputs are 0, state IDLE, time counter t=0, pending mask=0, write address=0, previous-i_play register=0. A reset mid-recording aborts it with no terminator written.
- Edge detect: edge = i_play & ~prev_play. prev_play updates every cycle in every state, so a button held across the start pulse does not log a note.
- States:
  - IDLE: i_rec_start -> REC, and clears t, address, count, pending and overflow. i_rec_stop is ignored.
  - REC: pending |= edge each cycle.
    - On i_tick: m = pending | edge. If m != 0 and the chart is not full, write {m, t} at the next cycle, increment address and count, and clear pending. t <= t+1, saturating at all-ones.
    - Full is defined as count == DEPTH-1; the last slot is reserved for the terminator. If m != 0 while full, m is dropped and o_overflow is set. Reaching full does not stop recording; only i_rec_stop does.
    - i_rec_stop -> FLUSH. i_rec_start is ignored.
  - FLUSH: if pending != 0 and not full, write {pending, t} this cycle. Then -> TERM.
  - TERM: write the terminator {2'b00, t} at the current address. Then -> DONE.
  - DONE: holds. i_rec_start -> REC with all clears.
- Timing: o_wr_en, o_wr_addr and o_wr_data are registered. A tick-cycle write appears one cycle after the tick. The press at cycle N with a tick at N is included in the entry for t.
- Simultaneous events:
  - Both tracks' edges in the same ms give one entry with mask 2'b11.
  - i_rec_stop on a tick cycle: that tick's entry is written first (as in REC), then FLUSH, then TERM. No entry is lost and no duplicate is written.
  - i_rec_start and i_rec_stop together in IDLE or DONE: start wins.
- At most one write per cycle. The terminator is always written, at address count, where count ≤ DEPTH-1.
- The time counter has TIME_W bits. It saturates and never wraps.

Decomposition:
- Shared game package holds: the entry layout (mask field position, TIME_W), the terminator encoding (mask 2'b00), and the track bit indices (TRK_UP=0, TRK_DN=1). note_gen uses the same package.
- The FSM and counters stay in one module. One sub-module is natural: edge_det2, a 2-bit rising-edge detector.

Test Plan:
- Basic: start; press bit0 during ms 5; stop at ms 20 -> writes addr0={01,5} and addr1={00,20}; count=1; o_done=1.
- Simultaneous and coalesce: bit0 and bit1 edges on different cycles of ms 7, plus a bit0 re-press in the same ms -> single entry {11,7}.
- Tick alignment: bit1 edge on the same cycle as the tick ending ms 3 -> entry {10,3}, with o_wr_en one cycle after that tick.
- Full: DEPTH=4; presses in ms 1..5 -> entries at addr0..2, o_overflow=1, stop writes terminator at addr3, count=3.
- Stop with pending: press at ms 9 then stop before the next tick -> FLUSH writes {01,9}, then TERM writes {00,9}.
- Reset mid-REC after 2 entries -> all outputs 0, IDLE, no terminator write. A new start writes from addr0 at t=0. Button held through start -> no entry.

Source files
------------

// File: rtl/chart_recorder_pkg.sv
// Shared chart-memory definitions: entry layout, terminator encoding, track indices
// and recorder states. note_gen imports the same package to read charts back.
package chart_recorder_pkg;

  localparam int unsigned TRK_UP = 0;
  localparam int unsigned TRK_DN = 1;

  localparam int unsigned MASK_W     = 2;
  localparam int unsigned TIME_W_DEF = 32;

  // Entry = {mask[MASK_W-1:0], time[TIME_W-1:0]}; the mask sits directly above the time.
  localparam logic [MASK_W-1:0] MASK_TERM = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC,
    ST_FLUSH,
    ST_TERM,
    ST_DONE
  } rec_state_t;

endpackage

// File: rtl/chart_recorder_edge_det2.sv
// Two-bit rising-edge detector; the previous-level register updates every cycle.
module edge_det2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_level,
  output logic [1:0] o_rise
);

  logic [1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= i_level;
  end

  assign o_rise = i_level & ~prev;

endmodule

// File: rtl/chart_recorder.sv
// Record-mode chart writer: timestamps play-button presses in ms, coalesces presses
// within one ms into a single entry, and closes the chart with a terminator entry.
module chart_recorder
  import chart_recorder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_tick,
  input  logic [1:0]               i_play,
  input  logic                     i_rec_start,
  input  logic                     i_rec_stop,
  output logic                     o_wr_en,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [TIME_W+MASK_W-1:0] o_wr_data,
  output logic                     o_recording,
  output logic                     o_done,
  output logic [ADDR_W:0]          o_count,
  output logic                     o_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH - 1);

  rec_state_t          state;
  logic [TIME_W-1:0]   t;
  logic [TIME_W-1:0]   t_next;
  logic [MASK_W-1:0]   pending;
  logic [MASK_W-1:0]   mask_now;
  logic [1:0]          rise;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     count;
  logic                overflow;
  logic                full;

  edge_det2 u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_play),
    .o_rise  (rise)
  );

  always_comb begin
    mask_now = pending | rise;
    full     = (count == FULL_CNT);
    t_next   = (t == '1) ? t : t + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      t         <= '0;
      pending   <= '0;
      addr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_rec_start) begin
            state    <= ST_REC;
            t        <= '0;
            pending  <= '0;
            addr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        ST_REC: begin
          // The tick-cycle edge joins this ms's entry, so tick handling uses mask_now.
          if (i_tick) begin
            pending <= '0;
            t       <= t_next;
            if (mask_now != '0) begin
              if (!full) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= addr;
                o_wr_data <= {mask_now, t};
                addr      <= addr + 1'b1;
                count     <= count + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else begin
            pending <= mask_now;
          end
          if (i_rec_stop) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          pending <= '0;
          if (pending != '0) begin
            if (!full) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= addr;
              o_wr_data <= {pending, t};
              addr      <= addr + 1'b1;
              count     <= count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          state <= ST_TERM;
        end
        ST_TERM: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= addr;
          o_wr_data <= {MASK_TERM, t};
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_recording = (state == ST_REC);
  assign o_done      = (state == ST_DONE);
  assign o_count     = count;
  assign o_overflow  = overflow;

endmodule
